// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce_sync block.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_CHK_HIGH = 2'd1,
    S_HIGH     = 2'd2,
    S_CHK_LOW  = 2'd3
  } state_e;

  localparam logic QResetVal  = 1'b0;
  localparam logic QnResetVal = 1'b1;

endpackage

// File: rtl/sync_chain.sv
// Plain flop-chain synchroniser for an asynchronous level input.
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic res_i,
  input  logic din_i,
  output logic sync_o
);

  if (SYNC_STAGES < 2) begin : gen_bad_stages
    $error("sync_chain: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] stage_q;

  // stage_q[0] may go metastable; only stage_q[SYNC_STAGES-1] leaves this module.
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], din_i};
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronise and debounce a raw level; emit clean q/qn and one-cycle rise/fall pulses.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk_i,
  input  logic res_i,
  input  logic din_i,
  output logic q_o,
  output logic qn_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  if (DEBOUNCE_CYCLES < 2) begin : gen_bad_cycles
    $error("debounce_sync: DEBOUNCE_CYCLES must be >= 2");
  end

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic            sync;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            q_q, q_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_chain (
    .clk_i (clk_i),
    .res_i (res_i),
    .din_i (din_i),
    .sync_o(sync)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (sync) begin
          state_d = S_CHK_HIGH;
          cnt_d   = CntOne;
        end
      end
      S_CHK_HIGH: begin
        if (!sync) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = S_HIGH;
          q_d     = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      S_HIGH: begin
        if (!sync) begin
          state_d = S_CHK_LOW;
          cnt_d   = CntOne;
        end
      end
      S_CHK_LOW: begin
        if (sync) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = S_LOW;
          q_d     = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset deliberately produces no fall pulse even when q was high.
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      q_q     <= QResetVal;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q_o    = q_q;
  assign qn_o   = ~q_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign busy_o = (state_q == S_CHK_HIGH) || (state_q == S_CHK_LOW);

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: constant vectors, corner sequences, random vs model.
module tb_debounce_sync;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 8;

  // {q, qn, rise, fall, busy}
  localparam logic [4:0] Idle0 = 5'b01000;
  localparam logic [4:0] Chk0  = 5'b01001;
  localparam logic [4:0] Rise1 = 5'b10100;
  localparam logic [4:0] High1 = 5'b10000;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic din = 1'b0;
  logic q, qn, rise, fall, busy;

  int checks = 0;
  int errors = 0;

  // Reference model: counts consecutive synchronised samples that disagree with q.
  bit pipe[$];
  int run;
  bit mq, mrise, mfall;

  int nrise, nfall, first_rise, first_fall;
  logic [4:0] got;

  typedef struct {
    bit         res;
    bit         din;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[$];

  debounce_sync #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_i (clk),
    .res_i (res),
    .din_i (din),
    .q_o   (q),
    .qn_o  (qn),
    .rise_o(rise),
    .fall_o(fall),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < SYNC; i++) pipe.push_back(1'b0);
    run   = 0;
    mq    = 1'b0;
    mrise = 1'b0;
    mfall = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit d);
    bit s;
    if (r) begin
      model_reset();
    end else begin
      s = pipe.pop_front();
      pipe.push_back(d);
      mrise = 1'b0;
      mfall = 1'b0;
      if (s != mq) begin
        run++;
        if (run == DEB) begin
          mq    = s;
          mrise = s;
          mfall = !s;
          run   = 0;
        end
      end else begin
        run = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit d);
    res = r;
    din = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    got = {q, qn, rise, fall, busy};
    check("model", {27'b0, got}, {27'b0, mq, !mq, mrise, mfall, (run != 0)});
  endtask

  task automatic hold(input bit d, input int n);
    nrise = 0;
    nfall = 0;
    first_rise = 0;
    first_fall = 0;
    for (int i = 1; i <= n; i++) begin
      step(1'b0, d);
      if (rise === 1'b1) begin
        nrise++;
        if (first_rise == 0) first_rise = i;
      end
      if (fall === 1'b1) begin
        nfall++;
        if (first_fall == 0) first_fall = i;
      end
    end
  endtask

  function automatic void add(input bit r, input bit d, input int n, input logic [4:0] e);
    vec_t v;
    v.res = r;
    v.din = d;
    v.exp = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  initial begin
    int acc;
    bit d;
    model_reset();

    // Reset with din=1, release, then a clean rise from q=0.
    add(1'b1, 1'b1, 3, Idle0);
    add(1'b0, 1'b1, 2, Idle0);
    add(1'b0, 1'b1, 7, Chk0);
    add(1'b0, 1'b1, 1, Rise1);
    add(1'b0, 1'b1, 1, High1);
    add(1'b1, 1'b0, 1, Idle0);
    add(1'b0, 1'b0, 3, Idle0);
    add(1'b0, 1'b1, 2, Idle0);
    add(1'b0, 1'b1, 7, Chk0);
    add(1'b0, 1'b1, 1, Rise1);
    add(1'b0, 1'b1, 9, High1);
    foreach (vecs[i]) begin
      step(vecs[i].res, vecs[i].din);
      check("vec", {27'b0, got}, {27'b0, vecs[i].exp});
    end

    // Glitch shorter than the debounce window never reaches q.
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    hold(1'b1, 5);
    acc = nrise;
    for (int i = 0; i < SYNC + 1; i++) step(1'b0, 1'b0);
    check("glitch_busy", {31'b0, busy}, 32'd0);
    hold(1'b0, 9);
    check("glitch_rise", acc + nrise, 32'd0);
    check("glitch_q", {31'b0, q}, 32'd0);

    // Bounce, then settle high: one rise, 10 edges after the final 0->1.
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      hold((k % 2) == 0, 3);
      acc += nrise;
    end
    hold(1'b1, 15);
    check("bounce_rise_cnt", acc + nrise, 32'd1);
    check("bounce_rise_at", first_rise, 32'd10);
    check("bounce_q", {31'b0, q}, 32'd1);

    // Short low glitch ignored, then a real fall.
    hold(1'b0, 4);
    acc = nfall;
    hold(1'b1, 10);
    check("lowglitch_fall", acc + nfall, 32'd0);
    check("lowglitch_q", {31'b0, q}, 32'd1);
    hold(1'b0, 15);
    check("fall_cnt", nfall, 32'd1);
    check("fall_at", first_fall, 32'd10);
    check("fall_no_rise", nrise, 32'd0);
    check("fall_qn", {31'b0, qn}, 32'd1);

    // Reset in the middle of qualification (cnt==5), then full latency again.
    hold(1'b1, 7);
    check("midchk_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1);
      check("midchk_rst", {27'b0, got}, {27'b0, Idle0});
    end
    hold(1'b1, 15);
    check("midchk_rise_at", first_rise, 32'd10);
    check("midchk_rise_cnt", nrise, 32'd1);

    // Reset while q=1: q drops with no fall pulse.
    step(1'b1, 1'b1);
    check("rst_high", {27'b0, got}, {27'b0, Idle0});

    // Random runs with occasional resets, checked every cycle against the model.
    d = 1'b0;
    for (int n = 0; n < 400; n++) begin
      int len;
      len = $urandom_range(1, 14);
      d = !d;
      for (int i = 0; i < len; i++) step(($urandom_range(0, 299) == 0), d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
